// File: rtl/ascon_cfg.sv
// Shared ASCON configuration constants: output-bus word type codes.
package ascon_cfg;

    localparam logic [2:0] D_NONE = 3'd0;
    localparam logic [2:0] D_TAG  = 3'd5;

endpackage

// File: rtl/put_tag_if.sv
// Tag input handshake plus bdo output bus for put_tag.
// The master modport is the put_tag side; slave is the core/downstream side.
interface put_tag_if #(
    parameter int unsigned TAG_W  = 128,
    parameter int unsigned DATA_W = 32
);

    logic              tag_valid;
    logic [TAG_W-1:0]  tag;
    logic              tag_ready;
    logic              bdo_valid;
    logic [2:0]        bdo_type;
    logic [DATA_W-1:0] bdo;
    logic              bdo_eot;
    logic              bdo_ready;

    modport master (
        input  tag_valid, tag, bdo_ready,
        output tag_ready, bdo_valid, bdo_type, bdo, bdo_eot
    );

    modport slave (
        output tag_valid, tag, bdo_ready,
        input  tag_ready, bdo_valid, bdo_type, bdo, bdo_eot
    );

endinterface

// File: rtl/put_tag.sv
// Serialises a computed tag MSB-word-first onto the bdo bus as D_TAG words,
// flagging the last word with eot and accepting the next tag on that word's transfer.
module put_tag
    import ascon_cfg::*;
#(
    parameter int unsigned TAG_W  = 128,
    parameter int unsigned DATA_W = 32
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    put_tag_if.master bus_io,
    input  logic     abort_i,
    output logic     busy_o,
    output logic     done_o
);

    localparam int unsigned WORDS = TAG_W / DATA_W;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WORDS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e           state_q;
    logic [TAG_W-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             eot_q;
    logic [2:0]       type_q;
    logic             done_q;

    logic last;
    logic xfer;
    logic load;

    assign last = (cnt_q == LastCnt);
    assign xfer = valid_q & bus_io.bdo_ready;
    // Ready on the final transfer lets a new tag follow without a bubble.
    assign bus_io.tag_ready = (state_q == StIdle) |
                              ((state_q == StSend) & last & bus_io.bdo_ready);
    assign load = bus_io.tag_valid & bus_io.tag_ready;

    assign bus_io.bdo_valid = valid_q;
    assign bus_io.bdo_type  = type_q;
    assign bus_io.bdo       = shift_q[TAG_W-1 -: DATA_W];
    assign bus_io.bdo_eot   = eot_q;
    assign busy_o           = (state_q == StSend);
    assign done_o           = done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            eot_q   <= 1'b0;
            type_q  <= D_NONE;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            eot_q   <= 1'b0;
            type_q  <= D_NONE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        state_q <= StSend;
                        shift_q <= bus_io.tag;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        eot_q   <= (LastCnt == '0);
                        type_q  <= D_TAG;
                    end
                end
                StSend: begin
                    if (xfer) begin
                        if (last) begin
                            done_q <= 1'b1;
                            if (load) begin
                                shift_q <= bus_io.tag;
                                cnt_q   <= '0;
                                eot_q   <= (LastCnt == '0);
                            end else begin
                                state_q <= StIdle;
                                shift_q <= '0;
                                cnt_q   <= '0;
                                valid_q <= 1'b0;
                                eot_q   <= 1'b0;
                                type_q  <= D_NONE;
                            end
                        end else begin
                            shift_q <= shift_q << DATA_W;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            eot_q   <= ((cnt_q + CNT_W'(1)) == LastCnt);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/put_tag.md
Name: put_tag

Overview:
- Transmit-side counterpart of the tag collector.
- Accepts a 128-bit computed tag from the ASCON core through a valid/ready handshake.
- Serialises the tag MSB-word-first onto the 32-bit output data bus (bdo), one word per accepted bus handshake, typed D_TAG, and flags the last word with end-of-type.
- Sits between the finalisation stage of the core and the output interface.

Parameters:
TAG_W, 128, tag width in bits; must be a multiple of DATA_W.
DATA_W, 32, output bus word width.
(derived) WORDS = TAG_W/DATA_W (4 by default); CNT_W = max(1, $clog2(WORDS)).

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous active-low reset.
tag_valid_i  in  1  core presents a tag on tag_i.
tag_i  in  TAG_W  tag; bits [TAG_W-1 -: DATA_W] are sent first.
tag_ready_o  out  1  block can take a tag this cycle.
abort_i  in  1  synchronous flush; drops any tag in flight.
bdo_valid_o  out  1  output word valid.
bdo_type_o  out  3  word type; D_TAG (ascon_cfg) whenever bdo_valid_o=1, 0 otherwise.
bdo_o  out  DATA_W  output word.
bdo_eot_o  out  1  high with the last word of the tag.
bdo_ready_i  in  1  downstream accepts the word.
busy_o  out  1  high while in SEND.
done_o  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
Clock, reset and package
- Single clock clk_i.
- Reset is asynchronous, active-low on rst_n_i.
- Imports ascon_cfg for D_TAG.

Reset state (all registers)
- State IDLE; shift register 0; counter 0.
- bdo_valid_o=0, bdo_o=0, bdo_type_o=0, bdo_eot_o=0, busy_o=0, done_o=0.
- tag_ready_o=1 (combinational from state).

Handshakes
- Load = tag_valid_i & tag_ready_o.
- Word xfer = bdo_valid_o & bdo_ready_i.

State IDLE
- tag_ready_o=1, bdo_valid_o=0.
- On load: shift_reg <= tag_i, cnt <= 0, state <= SEND.
- bdo_valid_o rises the cycle after load (1-cycle latency).

State SEND
- bdo_valid_o=1.
- bdo_o = shift_reg[TAG_W-1 -: DATA_W].
- bdo_eot_o = (cnt == WORDS-1).
- Valid, data, type and eot stay stable until xfer; bdo_valid_o never drops without xfer or abort.
- On xfer with cnt < WORDS-1: shift_reg <<= DATA_W (zero fill); cnt++.
- On xfer with cnt == WORDS-1: done_o=1 next cycle.
  - If load occurs the same cycle, go directly to SEND with the new tag. No bubble: the next word is valid in the following cycle.
  - Otherwise go to IDLE; shift_reg <= 0.
- tag_ready_o = (state==IDLE) | (state==SEND & cnt==WORDS-1 & bdo_ready_i).

Boundary conditions
- bdo_ready_i held low: output holds indefinitely; no word lost or repeated.
- bdo_ready_i high while bdo_valid_o=0: ignored.
- tag_valid_i during SEND before the last word: ignored (tag_ready_o=0); the core must hold it.
- abort_i=1 has priority over load and xfer: next cycle IDLE, shift_reg=0, cnt=0, all bdo outputs 0, no done_o.
- abort_i in IDLE: no effect. A load in that same cycle is discarded.
- Asynchronous reset mid-transfer: immediate return to reset state; no partial tag resumes.
- done_o is exactly one cycle wide per completed tag, including back-to-back tags.

Test Plan:
1. Reset, then tag_i=128'h00112233_44556677_8899AABB_CCDDEEFF with one-cycle tag_valid_i and bdo_ready_i=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles. bdo_type_o=D_TAG; eot only on CCDDEEFF; done_o pulses 1 cycle later; busy_o then low.
2. Same tag, bdo_ready_i toggling 1,0,0,1,0,1,1 -> each word held stable while ready=0; exactly 4 transfers in order; no duplicates.
3. Back-to-back: second tag 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF presented during the last word of the first -> tag_ready_o=1 in that cycle; DEADBEEF valid on the next cycle; 8 words in 8 cycles; two done_o pulses.
4. tag_valid_i asserted during word 2 of a tag -> tag_ready_o=0; the current tag completes unchanged; the held tag loads afterwards.
5. abort_i after word 1 accepted -> bdo_valid_o=0 next cycle, no done_o, busy_o=0; a new tag then transmits from its first word.
6. rst_n_i asserted low asynchronously mid-SEND (between clock edges) -> outputs reach reset values immediately; after release, a new tag transfers normally.
